// File: rtl/bench_axi_master_seq_pkg.sv
// Shared register map, status bit positions, error codes and state types
// for the router benchmark AXI4-Lite sequencer.
package bench_axi_master_seq_pkg;

  localparam logic [5:0]  REG_CONTROL = 6'h00;
  localparam logic [5:0]  REG_STATUS  = 6'h04;
  localparam logic [5:0]  REG_TCOND0  = 6'h08;
  localparam logic [5:0]  REG_WIN     = 6'h18;

  localparam int          STAT_DONE   = 1;
  localparam int          STAT_WIN_LO = 2;

  localparam logic [31:0] CTRL_START  = 32'h1;

  localparam logic [1:0]  ERR_NONE    = 2'd0;
  localparam logic [1:0]  ERR_BRESP   = 2'd1;
  localparam logic [1:0]  ERR_RRESP   = 2'd2;
  localparam logic [1:0]  ERR_TMO     = 2'd3;

  localparam logic [1:0]  RESP_OKAY   = 2'b00;

  typedef enum logic [2:0] {
    S_IDLE, S_WR, S_GAP, S_POLL, S_RD_AR, S_RD_R, S_FIN
  } seq_state_e;

  typedef enum logic [2:0] {
    X_IDLE, X_AW, X_B, X_AR, X_R
  } xfer_state_e;

  // Result registers TCOND0..3 then WIN_ONEHOT sit at consecutive words.
  function automatic logic [5:0] rd_addr(input logic [2:0] idx);
    return REG_TCOND0 + {1'b0, idx, 2'b00};
  endfunction

endpackage

// File: rtl/bench_axi_master_seq_xfer.sv
// One AXI4-Lite read or write: drives the channel handshakes, checks the
// response code and abandons the transfer if any phase stalls for TIMEOUT cycles.
module axil_single_xfer
  import bench_axi_master_seq_pkg::*;
#(
  parameter int TIMEOUT = 1024
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req,
  input  logic        we,
  input  logic [5:0]  addr,
  input  logic [31:0] wdata,
  output logic        ack,
  output logic        err,
  output logic        tmo,
  output logic [31:0] rdata,
  output logic [5:0]  m_axi_awaddr,
  output logic        m_axi_awvalid,
  input  logic        m_axi_awready,
  output logic [31:0] m_axi_wdata,
  output logic        m_axi_wvalid,
  input  logic        m_axi_wready,
  input  logic [1:0]  m_axi_bresp,
  input  logic        m_axi_bvalid,
  output logic        m_axi_bready,
  output logic [5:0]  m_axi_araddr,
  output logic        m_axi_arvalid,
  input  logic        m_axi_arready,
  input  logic [31:0] m_axi_rdata,
  input  logic [1:0]  m_axi_rresp,
  input  logic        m_axi_rvalid,
  output logic        m_axi_rready
);

  localparam int CW = $clog2(TIMEOUT + 1);

  xfer_state_e    state;
  logic [CW-1:0]  cnt;
  logic           expired, aw_ok, w_ok;

  assign expired = (cnt == CW'(TIMEOUT - 1));
  assign aw_ok   = !m_axi_awvalid || m_axi_awready;
  assign w_ok    = !m_axi_wvalid  || m_axi_wready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= X_IDLE;
      cnt           <= '0;
      ack           <= 1'b0;
      err           <= 1'b0;
      tmo           <= 1'b0;
      rdata         <= '0;
      m_axi_awaddr  <= '0;
      m_axi_awvalid <= 1'b0;
      m_axi_wdata   <= '0;
      m_axi_wvalid  <= 1'b0;
      m_axi_bready  <= 1'b0;
      m_axi_araddr  <= '0;
      m_axi_arvalid <= 1'b0;
      m_axi_rready  <= 1'b0;
    end else begin
      ack <= 1'b0;
      cnt <= cnt + 1'b1;
      case (state)
        X_IDLE: begin
          cnt <= '0;
          if (req && we) begin
            m_axi_awaddr  <= addr;
            m_axi_wdata   <= wdata;
            m_axi_awvalid <= 1'b1;
            m_axi_wvalid  <= 1'b1;
            state         <= X_AW;
          end else if (req) begin
            m_axi_araddr  <= addr;
            m_axi_arvalid <= 1'b1;
            state         <= X_AR;
          end
        end
        // AW and W retire independently; each valid falls right after its own handshake.
        X_AW: begin
          if (m_axi_awready) m_axi_awvalid <= 1'b0;
          if (m_axi_wready)  m_axi_wvalid  <= 1'b0;
          if (aw_ok && w_ok) begin
            m_axi_bready <= 1'b1;
            cnt          <= '0;
            state        <= X_B;
          end else if (expired) begin
            m_axi_awvalid <= 1'b0;
            m_axi_wvalid  <= 1'b0;
            {ack, tmo, err} <= 3'b110;
            state         <= X_IDLE;
          end
        end
        X_B: begin
          if (m_axi_bvalid) begin
            m_axi_bready <= 1'b0;
            ack          <= 1'b1;
            tmo          <= 1'b0;
            err          <= (m_axi_bresp != RESP_OKAY);
            state        <= X_IDLE;
          end else if (expired) begin
            m_axi_bready <= 1'b0;
            {ack, tmo, err} <= 3'b110;
            state        <= X_IDLE;
          end
        end
        X_AR: begin
          if (m_axi_arready) begin
            m_axi_arvalid <= 1'b0;
            m_axi_rready  <= 1'b1;
            cnt           <= '0;
            state         <= X_R;
          end else if (expired) begin
            m_axi_arvalid <= 1'b0;
            {ack, tmo, err} <= 3'b110;
            state         <= X_IDLE;
          end
        end
        X_R: begin
          if (m_axi_rvalid) begin
            m_axi_rready <= 1'b0;
            rdata        <= m_axi_rdata;
            ack          <= 1'b1;
            tmo          <= 1'b0;
            err          <= (m_axi_rresp != RESP_OKAY);
            state        <= X_IDLE;
          end else if (expired) begin
            m_axi_rready <= 1'b0;
            {ack, tmo, err} <= 3'b110;
            state        <= X_IDLE;
          end
        end
        default: state <= X_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/bench_axi_master_seq.sv
// Fabric-side AXI4-Lite initiator: starts the benchmark slave, polls STATUS
// until done, then captures TCOND0..3 and WIN_ONEHOT onto held outputs.
module bench_axi_master_seq
  import bench_axi_master_seq_pkg::*;
#(
  parameter int POLL_GAP  = 4,
  parameter int TIMEOUT   = 1024,
  parameter int MAX_POLLS = 65535
) (
  input  logic        m_axi_aclk,
  input  logic        m_axi_aresetn,
  input  logic        go,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic [1:0]  err_code,
  output logic [31:0] t_cond0,
  output logic [31:0] t_cond1,
  output logic [31:0] t_cond2,
  output logic [31:0] t_cond3,
  output logic [3:0]  win_onehot,
  output logic [1:0]  winner_code,
  output logic [5:0]  m_axi_awaddr,
  output logic        m_axi_awvalid,
  input  logic        m_axi_awready,
  output logic [31:0] m_axi_wdata,
  output logic [3:0]  m_axi_wstrb,
  output logic        m_axi_wvalid,
  input  logic        m_axi_wready,
  input  logic [1:0]  m_axi_bresp,
  input  logic        m_axi_bvalid,
  output logic        m_axi_bready,
  output logic [5:0]  m_axi_araddr,
  output logic        m_axi_arvalid,
  input  logic        m_axi_arready,
  input  logic [31:0] m_axi_rdata,
  input  logic [1:0]  m_axi_rresp,
  input  logic        m_axi_rvalid,
  output logic        m_axi_rready
);

  localparam int GW = $clog2(POLL_GAP + 1);
  localparam int PW = $clog2(MAX_POLLS + 1);

  seq_state_e   state;
  logic [GW-1:0] gap_cnt;
  logic [PW-1:0] poll_cnt;
  logic [2:0]    idx;

  logic        x_req, x_we, x_ack, x_err, x_tmo;
  logic [5:0]  x_addr;
  logic [31:0] x_wdata, x_rdata;

  assign m_axi_wstrb = 4'hF;

  // Requests are combinational so go reaches awvalid in a single cycle.
  always_comb begin
    x_req   = 1'b0;
    x_we    = 1'b0;
    x_addr  = REG_STATUS;
    x_wdata = CTRL_START;
    case (state)
      S_IDLE:  begin x_req = go; x_we = 1'b1; x_addr = REG_CONTROL; end
      S_GAP:   x_req = (gap_cnt == GW'(POLL_GAP - 1));
      S_RD_AR: begin x_req = 1'b1; x_addr = rd_addr(idx); end
      default: ;
    endcase
  end

  axil_single_xfer #(.TIMEOUT(TIMEOUT)) u_xfer (
    .clk(m_axi_aclk), .rst_n(m_axi_aresetn),
    .req(x_req), .we(x_we), .addr(x_addr), .wdata(x_wdata),
    .ack(x_ack), .err(x_err), .tmo(x_tmo), .rdata(x_rdata),
    .m_axi_awaddr(m_axi_awaddr), .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready),
    .m_axi_wdata(m_axi_wdata), .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(m_axi_wready),
    .m_axi_bresp(m_axi_bresp), .m_axi_bvalid(m_axi_bvalid), .m_axi_bready(m_axi_bready),
    .m_axi_araddr(m_axi_araddr), .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
    .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp), .m_axi_rvalid(m_axi_rvalid),
    .m_axi_rready(m_axi_rready)
  );

  always_ff @(posedge m_axi_aclk or negedge m_axi_aresetn) begin
    if (!m_axi_aresetn) begin
      state       <= S_IDLE;
      busy        <= 1'b0;
      done        <= 1'b0;
      error       <= 1'b0;
      err_code    <= ERR_NONE;
      t_cond0     <= '0;
      t_cond1     <= '0;
      t_cond2     <= '0;
      t_cond3     <= '0;
      win_onehot  <= '0;
      winner_code <= '0;
      gap_cnt     <= '0;
      poll_cnt    <= '0;
      idx         <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: if (go) begin
          busy        <= 1'b1;
          error       <= 1'b0;
          err_code    <= ERR_NONE;
          t_cond0     <= '0;
          t_cond1     <= '0;
          t_cond2     <= '0;
          t_cond3     <= '0;
          win_onehot  <= '0;
          winner_code <= '0;
          poll_cnt    <= '0;
          state       <= S_WR;
        end
        S_WR: if (x_ack) begin
          if (x_tmo || x_err) begin
            error    <= 1'b1;
            err_code <= x_tmo ? ERR_TMO : ERR_BRESP;
            state    <= S_FIN;
          end else begin
            gap_cnt <= '0;
            state   <= S_GAP;
          end
        end
        S_GAP: begin
          gap_cnt <= gap_cnt + 1'b1;
          if (x_req) state <= S_POLL;
        end
        S_POLL: if (x_ack) begin
          if (x_tmo || x_err) begin
            error    <= 1'b1;
            err_code <= x_tmo ? ERR_TMO : ERR_RRESP;
            state    <= S_FIN;
          end else if (x_rdata[STAT_DONE]) begin
            winner_code <= x_rdata[STAT_WIN_LO +: 2];
            idx         <= '0;
            state       <= S_RD_AR;
          end else if (poll_cnt == PW'(MAX_POLLS - 1)) begin
            error    <= 1'b1;
            err_code <= ERR_TMO;
            state    <= S_FIN;
          end else begin
            poll_cnt <= poll_cnt + 1'b1;
            gap_cnt  <= '0;
            state    <= S_GAP;
          end
        end
        S_RD_AR: state <= S_RD_R;
        S_RD_R: if (x_ack) begin
          if (x_tmo || x_err) begin
            error    <= 1'b1;
            err_code <= x_tmo ? ERR_TMO : ERR_RRESP;
            state    <= S_FIN;
          end else begin
            case (idx)
              3'd0:    t_cond0    <= x_rdata;
              3'd1:    t_cond1    <= x_rdata;
              3'd2:    t_cond2    <= x_rdata;
              3'd3:    t_cond3    <= x_rdata;
              default: win_onehot <= x_rdata[3:0];
            endcase
            if (idx == 3'd4) state <= S_FIN;
            else begin
              idx   <= idx + 1'b1;
              state <= S_RD_AR;
            end
          end
        end
        S_FIN: begin
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bench_axi_master_seq.sv
// Randomized bench: a behavioural slave with configurable stalls/faults, and an
// access-list/result model derived from the run configuration.
module tb_bench_axi_master_seq;

  localparam int POLL_GAP  = 3;
  localparam int TIMEOUT   = 20;
  localparam int MAX_POLLS = 6;

  logic clk = 1'b0, rst_n = 1'b0, go = 1'b0;
  logic busy, done, error;
  logic [1:0] err_code, winner_code;
  logic [31:0] t_cond0, t_cond1, t_cond2, t_cond3;
  logic [3:0] win_onehot;
  logic [5:0] awaddr, araddr;
  logic awvalid, awready = 0, wvalid, wready = 0, bvalid = 0, bready;
  logic arvalid, arready = 0, rvalid = 0, rready;
  logic [31:0] wdata, rdata = 0;
  logic [3:0] wstrb;
  logic [1:0] bresp = 0, rresp = 0;

  always #5 clk = ~clk;

  bench_axi_master_seq #(.POLL_GAP(POLL_GAP), .TIMEOUT(TIMEOUT), .MAX_POLLS(MAX_POLLS)) dut (
    .m_axi_aclk(clk), .m_axi_aresetn(rst_n), .go(go),
    .busy(busy), .done(done), .error(error), .err_code(err_code),
    .t_cond0(t_cond0), .t_cond1(t_cond1), .t_cond2(t_cond2), .t_cond3(t_cond3),
    .win_onehot(win_onehot), .winner_code(winner_code),
    .m_axi_awaddr(awaddr), .m_axi_awvalid(awvalid), .m_axi_awready(awready),
    .m_axi_wdata(wdata), .m_axi_wstrb(wstrb), .m_axi_wvalid(wvalid), .m_axi_wready(wready),
    .m_axi_bresp(bresp), .m_axi_bvalid(bvalid), .m_axi_bready(bready),
    .m_axi_araddr(araddr), .m_axi_arvalid(arvalid), .m_axi_arready(arready),
    .m_axi_rdata(rdata), .m_axi_rresp(rresp), .m_axi_rvalid(rvalid), .m_axi_rready(rready)
  );

  int checks = 0, fails = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // run configuration
  int unsigned c_aw_dly, c_w_dly, c_ar_dly, c_polls;
  bit c_bresp_err, c_stall;
  logic [5:0] c_slverr;
  logic [31:0] c_t[4];
  logic [3:0] c_win;
  logic [1:0] c_winner;
  logic [31:0] c_junk;

  // slave bookkeeping
  logic [6:0] log_q[$];
  int status_reads, viol, ar_high, aw_wait, w_wait, ar_wait, gap_idle;
  bit aw_got, w_got, gap_track;
  logic [5:0] aw_a;
  logic [31:0] w_d;
  logic p_awvalid, p_wvalid, p_bready, p_arvalid, p_rready;
  logic [5:0] p_awaddr, p_araddr;
  logic [31:0] p_wdata;

  // expectations
  logic [6:0] exp_q[$];
  logic [1:0] e_code, e_winner;
  logic [31:0] e_t[4];
  logic [3:0] e_win;

  // Slave: all activity at negedge; a handshake is valid-before-edge AND ready-before-edge.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        awready = 0; wready = 0; arready = 0; bvalid = 0; rvalid = 0;
        {p_awvalid, p_wvalid, p_bready, p_arvalid, p_rready} = '0;
        aw_got = 0; w_got = 0; aw_wait = 0; w_wait = 0; ar_wait = 0; gap_track = 0;
      end else begin
        bit hs_aw, hs_w, hs_b, hs_ar, hs_r;
        logic [31:0] junk;
        int k;
        hs_aw = p_awvalid && awready;
        hs_w  = p_wvalid && wready;
        hs_b  = bvalid && p_bready;
        hs_ar = p_arvalid && arready;
        hs_r  = rvalid && p_rready;
        if (p_awvalid && !hs_aw && (!awvalid || awaddr != p_awaddr)) viol++;
        if (p_wvalid && !hs_w && (!wvalid || wdata != p_wdata)) viol++;
        if ((hs_aw && awvalid) || (hs_w && wvalid)) viol++;
        if (p_arvalid && !hs_ar && !c_stall && (!arvalid || araddr != p_araddr)) viol++;
        if (arvalid && (awvalid || wvalid)) viol++;
        if (wvalid && wstrb != 4'hF) viol++;
        if (hs_aw) begin aw_got = 1; aw_a = p_awaddr; end
        if (hs_w)  begin w_got = 1; w_d = p_wdata; end
        if (hs_b) begin bvalid = 0; gap_track = 1; gap_idle = 0; end
        if (aw_got && w_got) begin
          log_q.push_back({1'b1, aw_a});
          if (w_d != 32'h1) viol++;
          aw_got = 0; w_got = 0;
          bvalid = 1; bresp = c_bresp_err ? 2'b10 : 2'b00;
        end
        if (hs_r) begin rvalid = 0; gap_track = 1; gap_idle = 0; end
        if (hs_ar) begin
          log_q.push_back({1'b0, p_araddr});
          junk = $urandom & c_junk;
          rvalid = 1;
          rresp = (p_araddr == c_slverr) ? 2'b10 : 2'b00;
          if (p_araddr == 6'h04) begin
            status_reads++;
            rdata = (status_reads >= int'(c_polls)) ? {junk[31:4], c_winner, 1'b1, junk[0]}
                                                  : {junk[31:2], 1'b0, junk[0]};
          end else if (p_araddr >= 6'h08 && p_araddr <= 6'h14) begin
            k = (int'(p_araddr) - 8) / 4;
            rdata = c_t[k];
          end else if (p_araddr == 6'h18) rdata = {junk[31:4], c_win};
          else rdata = junk;
        end
        // STATUS polls must be preceded by at least POLL_GAP idle cycles
        if (gap_track) begin
          if (arvalid) begin
            if (araddr == 6'h04 && gap_idle < POLL_GAP) viol++;
            gap_track = 0;
          end else gap_idle++;
        end
        awready = awvalid && (aw_wait >= int'(c_aw_dly));
        aw_wait = awvalid ? aw_wait + 1 : 0;
        wready = wvalid && (w_wait >= int'(c_w_dly));
        w_wait = wvalid ? w_wait + 1 : 0;
        arready = arvalid && !c_stall && (ar_wait >= int'(c_ar_dly));
        ar_wait = arvalid ? ar_wait + 1 : 0;
        if (arvalid) ar_high++;
        p_awvalid = awvalid; p_awaddr = awaddr; p_wvalid = wvalid; p_wdata = wdata;
        p_bready = bready; p_arvalid = arvalid; p_araddr = araddr; p_rready = rready;
      end
    end
  end

  task automatic set_clean();
    c_aw_dly = 0; c_w_dly = 0; c_ar_dly = 0; c_polls = 2;
    c_bresp_err = 0; c_stall = 0; c_slverr = 6'h3F; c_junk = 32'hFFFF_FFFF;
    for (int i = 0; i < 4; i++) c_t[i] = $urandom;
    c_win = 4'($urandom); c_winner = 2'($urandom);
  endtask

  // Expected access list and results, straight from the run rules.
  task automatic build_exp();
    logic [5:0] a;
    exp_q.delete();
    e_code = 0; e_winner = 0; e_win = 0;
    for (int i = 0; i < 4; i++) e_t[i] = 0;
    exp_q.push_back(7'h40);
    if (c_bresp_err) begin e_code = 1; return; end
    if (c_stall) begin e_code = 3; return; end
    for (int p = 1; p <= MAX_POLLS; p++) begin
      exp_q.push_back(7'h04);
      if (c_slverr == 6'h04) begin e_code = 2; return; end
      if (p >= int'(c_polls)) break;
      if (p == MAX_POLLS) begin e_code = 3; return; end
    end
    e_winner = c_winner;
    for (int k = 0; k < 5; k++) begin
      a = 6'(8 + 4 * k);
      exp_q.push_back({1'b0, a});
      if (c_slverr == a) begin e_code = 2; return; end
      if (k < 4) e_t[k] = c_t[k]; else e_win = c_win;
    end
  endtask

  // Called at a negedge; returns at the negedge where done is seen.
  task automatic run(input string nm);
    bit seen;
    build_exp();
    log_q.delete(); status_reads = 0; viol = 0; ar_high = 0;
    go = 1;
    @(posedge clk); #1;
    chk({nm, ":aw_lat"}, awvalid, 1);
    chk({nm, ":busy_acc"}, busy, 1);
    chk({nm, ":done_acc"}, done, 0);
    chk({nm, ":clr"}, {error, err_code, t_cond0, win_onehot, winner_code}, 0);
    @(negedge clk);
    go = 0;
    seen = 0;
    for (int c = 0; c < 3000 && !seen; c++) begin
      @(negedge clk);
      if (done) begin seen = 1; go = 0; end
      else go = busy && ($urandom_range(0, 7) == 0);
    end
    go = 0;
    if (!seen) begin chk({nm, ":done_seen"}, 0, 1); return; end
    chk({nm, ":busy_end"}, busy, 0);
    chk({nm, ":err_code"}, err_code, e_code);
    chk({nm, ":error"}, error, e_code != 0);
    chk({nm, ":t0"}, t_cond0, e_t[0]);
    chk({nm, ":t1"}, t_cond1, e_t[1]);
    chk({nm, ":t2"}, t_cond2, e_t[2]);
    chk({nm, ":t3"}, t_cond3, e_t[3]);
    chk({nm, ":win"}, win_onehot, e_win);
    chk({nm, ":winner"}, winner_code, e_winner);
    chk({nm, ":log_len"}, log_q.size(), exp_q.size());
    for (int i = 0; i < log_q.size() && i < exp_q.size(); i++)
      chk($sformatf("%s:log%0d", nm, i), log_q[i], exp_q[i]);
    chk({nm, ":proto"}, viol, 0);
    if (c_stall) chk({nm, ":ar_tmo_len"}, ar_high, TIMEOUT);
  endtask

  initial begin
    logic any;
    int r;
    bit hit;
    set_clean();
    repeat (3) @(negedge clk);
    #1;
    any = |{busy, done, error, err_code, t_cond0, t_cond1, t_cond2, t_cond3, win_onehot,
            winner_code, awvalid, wvalid, bready, arvalid, rready};
    chk("reset_outs", any, 0);
    rst_n = 1;
    @(negedge clk);

    set_clean(); c_polls = 3; c_junk = 0; c_winner = 2'd3; c_win = 4'h8;
    c_t[0] = 1; c_t[1] = 2; c_t[2] = 3; c_t[3] = 4;
    run("nominal");

    set_clean(); c_aw_dly = 1; c_w_dly = 4; run("skew");
    set_clean(); c_aw_dly = 4; c_w_dly = 0; run("skew2");
    set_clean(); c_slverr = 6'h0C; run("slverr");
    set_clean(); c_bresp_err = 1; run("bresp");
    set_clean(); c_stall = 1; run("stall");
    set_clean(); run("after_stall");
    set_clean(); c_polls = MAX_POLLS; run("poll_max");
    set_clean(); c_polls = MAX_POLLS + 1; run("poll_tmo");

    // Reset in the middle of a STATUS read
    set_clean(); c_polls = MAX_POLLS; build_exp();
    log_q.delete(); status_reads = 0;
    go = 1; @(negedge clk); go = 0;
    hit = 0;
    for (int c = 0; c < 500 && !hit; c++) begin
      @(negedge clk);
      if (rready && status_reads >= 2) hit = 1;
    end
    chk("mid_poll_reached", hit, 1);
    #2 rst_n = 0;
    #1;
    any = |{busy, done, error, err_code, t_cond0, t_cond1, t_cond2, t_cond3, win_onehot,
            winner_code, awvalid, wvalid, bready, arvalid, rready};
    chk("reset_mid_outs", any, 0);
    repeat (3) @(negedge clk);
    #1 rst_n = 1;
    any = 0;
    repeat (8) begin
      @(negedge clk);
      any = any | busy | awvalid | arvalid | done;
    end
    chk("idle_after_rst", any, 0);
    set_clean(); run("after_rst");

    for (int i = 0; i < 10; i++) begin
      set_clean();
      c_aw_dly = $urandom_range(0, 3); c_w_dly = $urandom_range(0, 3);
      c_ar_dly = $urandom_range(0, 3); c_polls = $urandom_range(1, MAX_POLLS + 1);
      r = $urandom_range(0, 9);
      if (r == 0) c_bresp_err = 1;
      else if (r == 1) c_slverr = 6'(4 * $urandom_range(1, 6));
      else if (r == 2) c_stall = 1;
      run($sformatf("rnd%0d", i));
    end

    @(negedge clk);
    chk("done_width", done, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
